// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tensor engine: FSM states, default
// sizing and the width helpers used by the engine and its datapath.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int IN_SIZE_DEF = 8;
    localparam int K_DEF       = 3;
    localparam int CH_DEF      = 3;
    localparam int NF_DEF      = 4;
    localparam int DWIDTH_DEF  = 17;
    localparam int BWIDTH_DEF  = 36;
    localparam int OWIDTH_DEF  = 36;

    function automatic int out_size(input int in_size, input int k);
        return in_size - k + 1;
    endfunction

    function automatic int acc_width(input int dw, input int k, input int ch);
        return 2 * dw + $clog2(k * k * ch);
    endfunction

    function automatic int addr_width(input int nf, input int o);
        return (nf * o * o > 1) ? $clog2(nf * o * o) : 1;
    endfunction

    localparam int OUT    = out_size(IN_SIZE_DEF, K_DEF);
    localparam int ACC_W  = acc_width(DWIDTH_DEF, K_DEF, CH_DEF);
    localparam int ADDR_W = addr_width(NF_DEF, OUT);

endpackage

// File: rtl/conv_pe_pipe.sv
// Three-stage convolution datapath: window multiply, adder tree, then
// bias/saturate/ReLU. Every stage advances only while i_en is high.
module conv_pe_pipe
    import conv_pkg::*;
#(
    parameter int IN_SIZE = IN_SIZE_DEF,
    parameter int K       = K_DEF,
    parameter int CH      = CH_DEF,
    parameter int NF      = NF_DEF,
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int BWIDTH  = BWIDTH_DEF,
    parameter int OWIDTH  = OWIDTH_DEF,
    parameter int RC_W    = 3,
    parameter int F_W     = 2,
    parameter int A_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic                     i_relu,
    input  logic [RC_W-1:0]          i_row,
    input  logic [RC_W-1:0]          i_col,
    input  logic [F_W-1:0]           i_filt,
    input  logic [A_W-1:0]           i_addr,
    input  logic                     i_last,
    input  logic signed [DWIDTH-1:0] i_ifmap   [IN_SIZE][IN_SIZE][CH],
    input  logic signed [DWIDTH-1:0] i_weights [NF][K][K][CH],
    input  logic signed [BWIDTH-1:0] i_bias    [NF],
    output logic                     o_valid,
    output logic signed [OWIDTH-1:0] o_data,
    output logic [A_W-1:0]           o_addr,
    output logic                     o_last,
    output logic                     o_busy
);

    localparam int TAPS   = K * K * CH;
    localparam int PROD_W = 2 * DWIDTH;
    localparam int AC_W   = acc_width(DWIDTH, K, CH);
    localparam int SUM_W  = ((AC_W > BWIDTH) ? AC_W : BWIDTH) + 1;
    localparam logic signed [OWIDTH-1:0] MAX_O = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic signed [OWIDTH-1:0] MIN_O = {1'b1, {(OWIDTH-1){1'b0}}};

    logic signed [PROD_W-1:0] w_prod [TAPS];
    logic signed [PROD_W-1:0] r_prod [TAPS];
    logic signed [AC_W-1:0]   w_acc_sum;
    logic signed [AC_W-1:0]   r_acc;
    logic signed [SUM_W-1:0]  w_biased;
    logic signed [OWIDTH-1:0] w_sat;
    logic signed [OWIDTH-1:0] w_result;
    logic                     w_fits;
    logic                     r_v1, r_v2, r_last1, r_last2;
    logic [F_W-1:0]           r_f1, r_f2;
    logic [A_W-1:0]           r_a1, r_a2;

    // Row/column offsets never exceed IN_SIZE-1, so RC_W-bit indices cannot wrap.
    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            for (genvar gc = 0; gc < CH; gc++) begin : g_ch
                assign w_prod[(gi * K + gj) * CH + gc] =
                    PROD_W'(i_weights[i_filt][gi][gj][gc]) *
                    PROD_W'(i_ifmap[i_row + RC_W'(gi)][i_col + RC_W'(gj)][gc]);
            end
        end
    end

    always_comb begin
        w_acc_sum = '0;
        for (int n = 0; n < TAPS; n++) begin
            w_acc_sum = w_acc_sum + AC_W'(r_prod[n]);
        end
    end

    assign w_biased = SUM_W'(r_acc) + SUM_W'(i_bias[r_f2]);
    assign w_fits   = (&w_biased[SUM_W-1:OWIDTH-1]) || !(|w_biased[SUM_W-1:OWIDTH-1]);
    assign w_sat    = w_fits ? w_biased[OWIDTH-1:0] : (w_biased[SUM_W-1] ? MIN_O : MAX_O);
    assign w_result = (i_relu && w_sat[OWIDTH-1]) ? '0 : w_sat;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_prod  <= w_prod;
            r_f1    <= i_filt;
            r_a1    <= i_addr;
            r_last1 <= i_last;
            r_acc   <= w_acc_sum;
            r_f2    <= r_f1;
            r_a2    <= r_a1;
            r_last2 <= r_last1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_addr  <= '0;
            o_last  <= 1'b0;
        end else if (i_en) begin
            r_v1    <= i_valid;
            r_v2    <= r_v1;
            o_valid <= r_v2;
            o_last  <= r_v2 && r_last2;
            if (r_v2) begin
                o_data <= w_result;
                o_addr <= r_a2;
            end
        end
    end

    assign o_busy = r_v1 || r_v2;

endmodule

// File: rtl/conv_tensor_engine.sv
// Convolution engine control: run FSM, position counters and the result
// stream handshake around the conv_pe_pipe datapath.
module conv_tensor_engine
    import conv_pkg::*;
#(
    parameter int IN_SIZE = IN_SIZE_DEF,
    parameter int K       = K_DEF,
    parameter int CH      = CH_DEF,
    parameter int NF      = NF_DEF,
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int BWIDTH  = BWIDTH_DEF,
    parameter int OWIDTH  = OWIDTH_DEF,
    localparam int O_SZ   = out_size(IN_SIZE, K),
    localparam int A_W    = addr_width(NF, O_SZ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic signed [DWIDTH-1:0] ifmap   [IN_SIZE][IN_SIZE][CH],
    input  logic signed [DWIDTH-1:0] weights [NF][K][K][CH],
    input  logic signed [BWIDTH-1:0] bias    [NF],
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] out_data,
    output logic [A_W-1:0]           out_addr,
    output logic                     out_last
);

    localparam int TOTAL = NF * O_SZ * O_SZ;
    localparam int RC_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int F_W   = (NF > 1) ? $clog2(NF) : 1;

    state_e          r_state, w_state_next;
    logic [RC_W-1:0] r_row, r_col;
    logic [F_W-1:0]  r_filt;
    logic [A_W-1:0]  r_addr;
    logic            r_relu;
    logic            w_en, w_issue, w_last_pos, w_pipe_busy;

    // A held output beat freezes the whole pipeline and the issue counters.
    assign w_en       = !out_valid || out_ready;
    assign w_issue    = (r_state == RUN) && w_en;
    assign w_last_pos = (r_addr == A_W'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_issue && w_last_pos) w_state_next = DRAIN;
            // Leave as the final beat transfers so done follows it directly.
            DRAIN:   if (!w_pipe_busy && (!out_valid || out_ready)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_filt <= '0;
            r_addr <= '0;
            r_relu <= 1'b0;
        end else if (r_state == IDLE) begin
            r_row  <= '0;
            r_col  <= '0;
            r_filt <= '0;
            r_addr <= '0;
            if (start) r_relu <= relu_en;
        end else if (w_issue) begin
            r_addr <= w_last_pos ? '0 : r_addr + A_W'(1);
            if (r_col == RC_W'(O_SZ - 1)) begin
                r_col <= '0;
                if (r_row == RC_W'(O_SZ - 1)) begin
                    r_row  <= '0;
                    r_filt <= (r_filt == F_W'(NF - 1)) ? '0 : r_filt + F_W'(1);
                end else begin
                    r_row <= r_row + RC_W'(1);
                end
            end else begin
                r_col <= r_col + RC_W'(1);
            end
        end
    end

    assign busy = (r_state == RUN) || (r_state == DRAIN);
    assign done = (r_state == DONE);

    conv_pe_pipe #(
        .IN_SIZE (IN_SIZE),
        .K       (K),
        .CH      (CH),
        .NF      (NF),
        .DWIDTH  (DWIDTH),
        .BWIDTH  (BWIDTH),
        .OWIDTH  (OWIDTH),
        .RC_W    (RC_W),
        .F_W     (F_W),
        .A_W     (A_W)
    ) u_pe_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_en),
        .i_valid   (w_issue),
        .i_relu    (r_relu),
        .i_row     (r_row),
        .i_col     (r_col),
        .i_filt    (r_filt),
        .i_addr    (r_addr),
        .i_last    (w_last_pos),
        .i_ifmap   (ifmap),
        .i_weights (weights),
        .i_bias    (bias),
        .o_valid   (out_valid),
        .o_data    (out_data),
        .o_addr    (out_addr),
        .o_last    (out_last),
        .o_busy    (w_pipe_busy)
    );

endmodule

// File: tb/tb_conv_tensor_engine.sv
// Self-checking bench for conv_tensor_engine: a plain-arithmetic convolution
// model predicts every beat; one monitor compares the stream each cycle.
module tb_conv_tensor_engine;

    localparam int IN_SIZE = 8;
    localparam int K       = 3;
    localparam int CH      = 3;
    localparam int NF      = 4;
    localparam int DW      = 17;
    localparam int BW      = 36;
    localparam int OW      = 36;
    localparam int OSZ     = IN_SIZE - K + 1;
    localparam int TOTAL   = NF * OSZ * OSZ;
    localparam longint SAT_MAX = 64'sd34359738367;
    localparam longint SAT_MIN = -64'sd34359738368;

    logic clk, rst, start, relu_en, out_ready;
    logic signed [DW-1:0] ifmap   [IN_SIZE][IN_SIZE][CH];
    logic signed [DW-1:0] weights [NF][K][K][CH];
    logic signed [BW-1:0] bias    [NF];
    logic                 busy, done, out_valid, out_last;
    logic signed [OW-1:0] out_data;
    logic [7:0]           out_addr;

    int     checks = 0;
    int     failures = 0;
    longint exp_data [TOTAL];
    int     beat_cnt, done_cnt, stall_obs, stall_done, rdy_mode;
    int     cyc = 0, last_cyc, done_cyc;
    bit     mon_en = 0;
    logic signed [OW-1:0] first_data;
    bit                   prev_stall = 0;
    logic signed [OW-1:0] prev_data;
    logic [7:0]           prev_addr;
    logic                 prev_last;

    conv_tensor_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .relu_en   (relu_en),
        .ifmap     (ifmap),
        .weights   (weights),
        .bias      (bias),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (beat %0d)", name, act, exp, beat_cnt);
        end
    endtask

    function automatic void build_model();
        longint s;
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < OSZ; r++)
                for (int c = 0; c < OSZ; c++) begin
                    s = longint'(bias[f]);
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            for (int ch = 0; ch < CH; ch++)
                                s += longint'(weights[f][i][j][ch]) * longint'(ifmap[r+i][c+j][ch]);
                    if (s > SAT_MAX) s = SAT_MAX;
                    else if (s < SAT_MIN) s = SAT_MIN;
                    if (relu_en && s < 0) s = 0;
                    exp_data[f*OSZ*OSZ + r*OSZ + c] = s;
                end
    endfunction

    task automatic fill_const(input int iv, input int wv, input longint bv);
        for (int a = 0; a < IN_SIZE; a++)
            for (int b = 0; b < IN_SIZE; b++)
                for (int c = 0; c < CH; c++) ifmap[a][b][c] = iv[DW-1:0];
        for (int f = 0; f < NF; f++) begin
            bias[f] = bv[BW-1:0];
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    for (int c = 0; c < CH; c++) weights[f][i][j][c] = wv[DW-1:0];
        end
    endtask

    task automatic fill_random(input int mag, input bit bfull);
        int iv;
        logic [63:0] bt;
        for (int a = 0; a < IN_SIZE; a++)
            for (int b = 0; b < IN_SIZE; b++)
                for (int c = 0; c < CH; c++) begin
                    iv = int'($urandom_range(0, 2 * mag)) - mag;
                    ifmap[a][b][c] = iv[DW-1:0];
                end
        for (int f = 0; f < NF; f++) begin
            bt = {$urandom, $urandom};
            if (!bfull) begin
                iv = int'($urandom_range(0, 2000000)) - 1000000;
                bt = 64'(longint'(iv));
            end
            bias[f] = bt[BW-1:0];
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    for (int c = 0; c < CH; c++) begin
                        iv = int'($urandom_range(0, 2 * mag)) - mag;
                        weights[f][i][j][c] = iv[DW-1:0];
                    end
        end
    endtask

    // Ready pattern: 0 always ready, 1 random, 2 five-cycle stall at beat 10.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 9) < 7);
                2: if (beat_cnt == 10 && stall_done < 5) begin
                       out_ready = 1'b0;
                       stall_done++;
                   end else out_ready = 1'b1;
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
            if (mon_en && out_valid) begin
                check("busy_with_beat", busy, 1);
                if (prev_stall) begin
                    check("hold_data", out_data, prev_data);
                    check("hold_addr", out_addr, prev_addr);
                    check("hold_last", out_last, prev_last);
                end
                if (out_ready) begin
                    if (beat_cnt >= TOTAL) begin
                        check("extra_beat", beat_cnt, TOTAL - 1);
                    end else begin
                        check("addr", out_addr, beat_cnt);
                        check("data", out_data, exp_data[beat_cnt]);
                        check("last", out_last, (beat_cnt == TOTAL - 1));
                    end
                    if (beat_cnt == 0) first_data = out_data;
                    last_cyc = cyc;
                    beat_cnt++;
                end else begin
                    stall_obs++;
                end
            end
            prev_stall = mon_en && out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
            prev_last  = out_last;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic arm(input int mode);
        build_model();
        beat_cnt = 0; done_cnt = 0; stall_obs = 0; stall_done = 0;
        first_data = '0; last_cyc = -10; done_cyc = -100;
        rdy_mode = mode;
        mon_en = 1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic run_test(input string name, input int mode, input bit lat_chk, input bit dbl_start);
        arm(mode);
        @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        pulse_start();
        @(negedge clk);
        check({name, "_busy_after_start"}, busy, 1);
        if (lat_chk) begin
            @(posedge clk); @(posedge clk); @(negedge clk);
            check("latency_early", out_valid, 0);
            @(posedge clk); @(negedge clk);
            check("latency", out_valid, 1);
        end
        if (dbl_start) begin
            repeat (20) @(posedge clk);
            #1 start = 1; relu_en = ~relu_en;
            @(posedge clk); #1 start = 0;
        end
        for (int n = 0; n < 4000 && done_cnt == 0; n++) @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check({name, "_beats"}, beat_cnt, TOTAL);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_timing"}, done_cyc, last_cyc + 1);
        mon_en = 0;
        rdy_mode = 0;
        $display("run %s: beats=%0d done_pulses=%0d stalls=%0d first=%0d", name, beat_cnt, done_cnt, stall_obs, first_data);
    endtask

    initial begin
        rst = 1; start = 0; relu_en = 0; rdy_mode = 0;
        fill_const(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", out_addr, 0);
        @(posedge clk); #1 rst = 0;

        fill_const(1, 1, 0); relu_en = 1;
        run_test("all_ones", 0, 1, 0);
        check("pin_ones_first", first_data, 27);
        check("pin_model_ones", exp_data[77], 27);

        fill_const(1, -1, 0); relu_en = 1;
        run_test("neg_relu", 0, 0, 0);
        check("pin_neg_relu", first_data, 0);
        relu_en = 0;
        run_test("neg_raw", 0, 0, 0);
        check("pin_neg_raw", first_data, -27);

        fill_random(1000, 0); relu_en = 0;
        run_test("stall10", 2, 0, 0);
        check("stall10_cycles", stall_obs, 5);

        fill_const(65535, 65535, 64'sd1048576); relu_en = 1;
        run_test("saturate", 0, 0, 0);
        check("pin_sat_first", first_data, SAT_MAX);
        check("pin_model_sat", exp_data[TOTAL-1], SAT_MAX);

        fill_random(65536, 1); relu_en = 0;
        arm(0);
        pulse_start();
        for (int n = 0; n < 2000 && beat_cnt < 50; n++) @(negedge clk);
        check("abort_reached50", (beat_cnt >= 50), 1);
        @(posedge clk); #1 rst = 1; mon_en = 0;
        @(posedge clk); @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", out_addr, 0);
        check("abort_last", out_last, 0);
        @(posedge clk); #1 rst = 0;
        done_cnt = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_valid", out_valid, 0);
        $display("run abort: beats_before_reset>=50");
        run_test("after_abort", 0, 0, 0);

        fill_random(3000, 0); relu_en = 1;
        run_test("double_start", 0, 0, 1);

        for (int t = 0; t < 3; t++) begin
            fill_random((t == 0) ? 65536 : 500, (t == 0));
            relu_en = $urandom_range(0, 1);
            run_test($sformatf("random%0d", t), 1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_tensor_engine.md
CONV_TENSOR_ENGINE -- requirements
Module: conv_tensor_engine

Interface
REQ-001 Parameter IN_SIZE, 8, input feature-map height/width.
REQ-002 Parameter K, 3, square kernel size; OUT = IN_SIZE-K+1 (6 at defaults).
REQ-003 Parameter CH, 3, input channels.
REQ-004 Parameter NF, 4, filter count.
REQ-005 Parameter DWIDTH, 17, signed data and weight width.
REQ-006 Parameter BWIDTH, 36, signed bias width.
REQ-007 Parameter OWIDTH, 36, signed result width.
REQ-008 clk  in  1  single clock; all state updates on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 start  in  1  one-cycle run request.
REQ-011 relu_en  in  1  1 = ReLU applied, 0 = raw biased sum.
REQ-012 ifmap  in  [IN_SIZE][IN_SIZE][CH]xDWIDTH signed  input tensor, held stable while busy.
REQ-013 weights  in  [NF][K][K][CH]xDWIDTH signed  filters, held stable while busy.
REQ-014 bias  in  [NF]xBWIDTH signed  per-filter bias, held stable while busy.
REQ-015 busy  out  1  high from the cycle after start is accepted until done.
REQ-016 done  out  1  one-cycle pulse after the last beat is accepted.
REQ-017 out_valid  out  1; out_ready  in  1  valid/ready result stream.
REQ-018 out_data  out  OWIDTH signed; out_addr  out  $clog2(NF*OUT*OUT); out_last  out  1.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, RUN->DRAIN after the last position is issued, DRAIN->DONE when the pipeline is empty, DONE->IDLE after one cycle.
REQ-020 start is ignored outside IDLE.
REQ-021 Issue order: filter outermost, then row, then column; out_addr = f*OUT*OUT + r*OUT + c.
REQ-022 Each issued position computes sum over i,j<K and ch<CH of weights[f][i][j][ch]*ifmap[r+i][c+j][ch], at full precision (2*DWIDTH + $clog2(K*K*CH) bits).
REQ-023 Bias is sign-extended and added at full precision; the result saturates to the signed OWIDTH range.
REQ-024 With relu_en=1, negative results become 0; relu_en is sampled with start and held for the run.
REQ-025 Pipeline has 3 register stages: window multiply, adder tree, bias/saturate/ReLU.
REQ-026 With no back-pressure, beat 0 out_valid asserts 4 cycles after the cycle in which start is sampled high; one beat per cycle follows.
REQ-027 When out_valid=1 and out_ready=0, the whole pipeline and issue counters stall; out_data, out_addr and out_last hold stable.
REQ-028 A beat transfers on out_valid && out_ready; exactly NF*OUT*OUT beats transfer per run.
REQ-029 out_last=1 only on the beat with out_addr = NF*OUT*OUT-1.
REQ-030 done pulses in the DONE cycle; busy drops in the same cycle.
REQ-031 Counters wrap column->row->filter with no skipped or repeated positions.

Reset
REQ-032 rst=1 forces IDLE, clears all counters and pipeline valid bits, and drives busy, done, out_valid and out_last to 0, and out_data and out_addr to 0 on the next edge.
REQ-033 rst mid-run aborts the run: no further beats, no done pulse; the next start begins again at out_addr 0.

Structure
REQ-034 Package conv_pkg holds the FSM state enum, the default parameter values, and the width helper constants (OUT, ACC_W, ADDR_W).
REQ-035 One sub-module, conv_pe_pipe, implements the window-MAC plus bias/ReLU datapath with a stall enable; conv_tensor_engine holds the FSM, counters and handshake.

Verification
REQ-036 All ifmap=1, all weights=1, bias=0, relu_en=1, out_ready=1 -> 144 beats, each out_data=27, addr 0..143, out_last on 143, done 1 cycle later.
REQ-037 All weights=-1, ifmap=1, bias=0 -> out_data=0 with relu_en=1; out_data=-27 with relu_en=0.
REQ-038 out_ready=0 for 5 cycles at beat 10 -> beat 10 held unchanged, no loss or duplication, 144 beats total.
REQ-039 All ifmap=65535, all weights=65535, bias=2^20 -> every out_data=2^35-1 (saturated).
REQ-040 rst asserted at beat 50 -> out_valid=0 and busy=0 next cycle, no done pulse; restart yields addr 0..143 correctly.
REQ-041 start pulsed again during RUN -> ignored; exactly 144 beats and one done pulse.
